// File: rtl/uart_bus_peripheral.sv
// uart_bus_peripheral: memory-mapped 8N1 UART with a zero-wait-state bus interface.
// Register map (addr[1:0]): 0 DATA, 1 STATUS, 2 BAUD, 3 CTRL.
// Build option: define UART_LOOPBACK_EN to make CTRL bit0 an internal loopback
// (RX is fed from the TX engine and the tx pin is held idle-high).
//
// TX / RX engine states
//   state    | meaning
//   ST_IDLE  | line idle; TX: waiting for a DATA write, RX: waiting for a start edge
//   ST_START | start bit; TX drives 0, RX waits half a bit period to confirm it
//   ST_DATA  | eight data bits, LSB first, one divisor period each
//   ST_STOP  | stop bit; TX drives 1, RX samples it and pushes or flags frame_err
module uart_bus_peripheral #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        UART_SEL_H,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [15:0] BAUD_RST = 16'(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_BAUD   = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  // bus tracking
  logic       acc, acc_start, acc_end;
  logic       acc_q, acc_d;
  logic [1:0] rd_addr_q, rd_addr_d;
  logic       rd_q, rd_d;
  logic       wr_en, wr_data, wr_status, wr_baud, wr_ctrl;

  // configuration and sticky flags
  logic [15:0] baud_q, baud_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        loopback;

  // transmitter
  logic [1:0]  tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_line_q, tx_line_d;

  // receiver
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic        rx_in;
  logic [1:0]  rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_arm_q, rx_arm_d;
  logic        push_req, frame_set;

  // RX FIFO
  logic [7:0]    mem_q [RX_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] count;
  logic [8:0]    count9;
  logic          empty, full, push_en, pop_en;

  logic unused_bits;
  assign unused_bits = ^{addr[31:2], wdata[31:16], count9[8]};

  assign acc       = UART_SEL_H & ~AS_L;
  assign acc_start = acc & ~acc_q;
  assign acc_end   = ~acc & acc_q;
  assign wr_en     = acc_start & ~WE_L;
  assign wr_data   = wr_en & (addr[1:0] == A_DATA);
  assign wr_status = wr_en & (addr[1:0] == A_STATUS);
  assign wr_baud   = wr_en & (addr[1:0] == A_BAUD);
  assign wr_ctrl   = wr_en & (addr[1:0] == A_CTRL);

`ifdef UART_LOOPBACK_EN
  logic lb_q, lb_d;

  // CTRL loopback bit
  always_comb begin
    lb_d = lb_q;
    if (wr_ctrl) lb_d = wdata[0];
  end

  // CTRL register
  always_ff @(posedge clk) begin
    if (reset) lb_q <= 1'b0;
    else       lb_q <= lb_d;
  end

  assign loopback = lb_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = wr_ctrl;
  assign loopback    = 1'b0;
`endif

  assign tx    = loopback ? 1'b1 : tx_line_q;
  assign rx_in = loopback ? tx_line_q : rx_s2_q;

  // bus edge tracking, register writes and sticky flags
  always_comb begin
    acc_d       = acc;
    rd_addr_d   = acc_start ? addr[1:0] : rd_addr_q;
    rd_d        = acc_start ? WE_L : rd_q;
    baud_d      = baud_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_baud) baud_d = (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
    if (wr_status && wdata[3]) overrun_d = 1'b0;
    if (wr_status && wdata[4]) frame_err_d = 1'b0;
    if (push_req && full && !pop_en) overrun_d = 1'b1;
    if (frame_set) frame_err_d = 1'b1;
  end

  // transmit engine; the divisor is latched when a frame starts
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_sh_d  = tx_sh_q;
    tx_bit_d = tx_bit_q;
    case (tx_st_q)
      ST_IDLE: begin
        if (wr_data) begin
          tx_st_d  = ST_START;
          tx_div_d = baud_q;
          tx_cnt_d = baud_q - 16'd1;
          tx_sh_d  = wdata[7:0];
          tx_bit_d = 3'd0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_st_d  = ST_DATA;
          tx_cnt_d = tx_div_q - 16'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_st_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        if (tx_cnt_q == 16'd0) tx_st_d = ST_IDLE;
        else                   tx_cnt_d = tx_cnt_q - 16'd1;
      end
    endcase
    tx_line_d = 1'b1;
    if (tx_st_d == ST_START)     tx_line_d = 1'b0;
    else if (tx_st_d == ST_DATA) tx_line_d = tx_sh_d[0];
  end

  // receive engine; after a framing error it waits for a high line before re-arming
  always_comb begin
    rx_s1_d   = rx;
    rx_s2_d   = rx_s1_q;
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_div_d  = rx_div_q;
    rx_sh_d   = rx_sh_q;
    rx_bit_d  = rx_bit_q;
    rx_arm_d  = rx_arm_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (rx_st_q)
      ST_IDLE: begin
        if (!rx_arm_q) begin
          if (rx_in) rx_arm_d = 1'b1;
        end else if (!rx_in) begin
          rx_st_d  = ST_START;
          rx_div_d = baud_q;
          rx_cnt_d = (baud_q >> 1) - 16'd1;
        end
      end
      ST_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_in) begin
            rx_st_d = ST_IDLE;
          end else begin
            rx_st_d  = ST_DATA;
            rx_cnt_d = rx_div_q - 16'd1;
            rx_bit_d = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_in, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          rx_cnt_d = rx_div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: begin
        if (rx_cnt_q == 16'd0) begin
          rx_st_d = ST_IDLE;
          if (rx_in) begin
            push_req = 1'b1;
          end else begin
            frame_set = 1'b1;
            rx_arm_d  = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  // FIFO pointers; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    count  = wptr_q - rptr_q;
    count9 = 9'(count);
    empty  = (count == '0);
    full   = (count == PW'(RX_DEPTH));
    pop_en = acc_end & rd_q & (rd_addr_q == A_DATA) & ~empty;
    push_en = push_req & (~full | pop_en);
    wptr_d = wptr_q + PW'(push_en);
    rptr_d = rptr_q + PW'(pop_en);
  end

  // read data mux, live only while the access is active
  always_comb begin
    rdata = 32'd0;
    if (acc) begin
      case (addr[1:0])
        A_DATA:   if (!empty) rdata[7:0] = mem_q[rptr_q[AW-1:0]];
        A_STATUS: begin
          rdata[0]    = ~empty;
          rdata[1]    = (tx_st_q == ST_IDLE);
          rdata[2]    = full;
          rdata[3]    = overrun_q;
          rdata[4]    = frame_err_q;
          rdata[15:8] = count9[7:0];
        end
        A_BAUD:   rdata[15:0] = baud_q;
        default:  rdata[0] = loopback;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= rx_sh_q;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= 1'b0;
      rd_addr_q   <= 2'd0;
      rd_q        <= 1'b0;
      baud_q      <= BAUD_RST;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_st_q     <= ST_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= BAUD_RST;
      tx_sh_q     <= 8'd0;
      tx_bit_q    <= 3'd0;
      tx_line_q   <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_st_q     <= ST_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_div_q    <= BAUD_RST;
      rx_sh_q     <= 8'd0;
      rx_bit_q    <= 3'd0;
      rx_arm_q    <= 1'b1;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      acc_q       <= acc_d;
      rd_addr_q   <= rd_addr_d;
      rd_q        <= rd_d;
      baud_q      <= baud_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_sh_q     <= tx_sh_d;
      tx_bit_q    <= tx_bit_d;
      tx_line_q   <= tx_line_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_sh_q     <= rx_sh_d;
      rx_bit_q    <= rx_bit_d;
      rx_arm_q    <= rx_arm_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_peripheral.sv
// Directed bench for uart_bus_peripheral: register table, TX frame, RX/FIFO, errors, loopback.
module tb_uart_bus_peripheral;

  localparam int BAUD = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_BAUD = 2'd2, A_CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        AS_L, WE_L, UART_SEL_H;
  logic [31:0] addr, wdata, rdata;
  logic        tx, rx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  uart_bus_peripheral #(.CLKS_PER_BIT(434), .RX_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .AS_L(AS_L), .WE_L(WE_L), .UART_SEL_H(UART_SEL_H),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    UART_SEL_H = 1'b0;
    AS_L       = 1'b1;
    WE_L       = 1'b1;
    addr       = 32'd0;
    wdata      = 32'd0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    UART_SEL_H = 1'b1; AS_L = 1'b0; WE_L = 1'b0;
    addr = {30'd0, a}; wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [1:0] a, input int ncyc, input logic [31:0] exp, input string nm);
    @(negedge clk);
    UART_SEL_H = 1'b1; AS_L = 1'b0; WE_L = 1'b1;
    addr = {30'd0, a};
    for (int i = 0; i < ncyc; i++) begin
      #1;
      chk($sformatf("%s_c%0d", nm, i), rdata, exp);
      @(negedge clk);
    end
    bus_idle();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    logic [9:0] txe;
    txe = {1'b1, 8'hA5, 1'b0};

    vecs[0]  = '{1'b0, A_STATUS, 32'd0,          32'h0000_0002};
    vecs[1]  = '{1'b0, A_BAUD,   32'd0,          32'h0000_01B2};
    vecs[2]  = '{1'b0, A_DATA,   32'd0,          32'h0000_0000};
    vecs[3]  = '{1'b0, A_CTRL,   32'd0,          32'h0000_0000};
    vecs[4]  = '{1'b1, A_BAUD,   32'd3,          32'd0};
    vecs[5]  = '{1'b0, A_BAUD,   32'd0,          32'h0000_0004};
    vecs[6]  = '{1'b1, A_BAUD,   32'h0001_2345,  32'd0};
    vecs[7]  = '{1'b0, A_BAUD,   32'd0,          32'h0000_2345};
    vecs[8]  = '{1'b1, A_BAUD,   32'd5,          32'd0};
    vecs[9]  = '{1'b0, A_BAUD,   32'd0,          32'h0000_0005};
    vecs[10] = '{1'b1, A_STATUS, 32'h18,         32'd0};
    vecs[11] = '{1'b0, A_STATUS, 32'd0,          32'h0000_0002};
    vecs[12] = '{1'b1, A_BAUD,   32'd8,          32'd0};
    vecs[13] = '{1'b0, A_BAUD,   32'd0,          32'h0000_0008};

    bus_idle();
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].d);
      else            bus_rd(vecs[i].a, 1, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // TX frame 0xA5 at divisor 8, with a discarded DATA write mid-frame
    bus_wr(A_DATA, 32'hA5);
    for (int i = 0; i < 90; i++) begin
      bus_idle();
      if (i == 1 || i == 20 || i == 78 || i == 80) begin
        UART_SEL_H = 1'b1; AS_L = 1'b0; WE_L = 1'b1; addr = {30'd0, A_STATUS};
      end
      if (i == 30) begin
        UART_SEL_H = 1'b1; AS_L = 1'b0; WE_L = 1'b0; addr = {30'd0, A_DATA}; wdata = 32'hFF;
      end
      #1;
      if (i < 80 && (i % 8) == 4)
        chk($sformatf("tx_bit%0d", i / 8), {31'd0, tx}, {31'd0, txe[i / 8]});
      if (i == 1 || i == 20 || i == 78) chk($sformatf("tx_busy_status_%0d", i), rdata, 32'h0);
      if (i == 80) chk("tx_done_status", rdata, 32'h2);
      if (i == 86) chk("tx_idle_after_frame", {31'd0, tx}, 32'd1);
      @(negedge clk);
    end
    bus_idle();

    // two RX frames, multi-cycle read pops once
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    @(negedge clk);
    #1;
    chk("rdata_idle_zero", rdata, 32'd0);
    bus_rd(A_STATUS, 1, 32'h0000_0203, "rx2_status");
    bus_rd(A_DATA,   3, 32'h0000_003C, "rx_data0_3cyc");
    bus_rd(A_STATUS, 1, 32'h0000_0103, "rx1_status");
    bus_rd(A_DATA,   1, 32'h0000_0081, "rx_data1");
    bus_rd(A_STATUS, 1, 32'h0000_0002, "rx0_status");
    bus_rd(A_DATA,   1, 32'h0000_0000, "data_empty");
    bus_rd(A_STATUS, 1, 32'h0000_0002, "empty_read_no_effect");

    // overflow: 17 frames into a 16-deep FIFO
    for (int k = 0; k < 17; k++) send_frame(8'(16 + k), 1'b1);
    bus_rd(A_STATUS, 1, 32'h0000_100F, "full_overrun_status");
    bus_wr(A_STATUS, 32'h8);
    bus_rd(A_STATUS, 1, 32'h0000_1007, "overrun_cleared");
    for (int k = 0; k < 16; k++)
      bus_rd(A_DATA, 1, 32'(16 + k), $sformatf("fifo_byte%0d", k));
    bus_rd(A_STATUS, 1, 32'h0000_0002, "fifo_drained");

    // framing error, then glitch rejection, then a clean frame
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    bus_rd(A_STATUS, 1, 32'h0000_0012, "frame_err_status");
    bus_wr(A_STATUS, 32'h10);
    bus_rd(A_STATUS, 1, 32'h0000_0002, "frame_err_cleared");
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    bus_rd(A_STATUS, 1, 32'h0000_0002, "glitch_status");
    send_frame(8'h6B, 1'b1);
    bus_rd(A_STATUS, 1, 32'h0000_0103, "rearm_status");
    bus_rd(A_DATA,   1, 32'h0000_006B, "rearm_data");

`ifdef UART_LOOPBACK_EN
    begin
      int low_cnt;
      low_cnt = 0;
      bus_wr(A_CTRL, 32'h1);
      bus_rd(A_CTRL, 1, 32'h1, "ctrl_loopback");
      bus_wr(A_DATA, 32'h5A);
      for (int i = 0; i < 100; i++) begin
        #1;
        if (tx !== 1'b1) low_cnt++;
        @(negedge clk);
      end
      chk("lb_tx_pin_low_cycles", 32'(low_cnt), 32'd0);
      bus_rd(A_STATUS, 1, 32'h0000_0103, "lb_status");
      bus_rd(A_DATA,   1, 32'h0000_005A, "lb_data");
      bus_wr(A_CTRL, 32'h0);
    end
`else
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_CTRL, 1, 32'h0, "ctrl_disabled");
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_peripheral.md
Name: uart_bus_peripheral

Overview:
- Memory-mapped 8N1 UART peripheral on the CPU data bus.
- Serialises CPU writes onto the tx pin and deserialises the rx pin into an RX FIFO.
- Returns register contents on rdata, which feeds the CPU read-data multiplexer when UART_SEL_H is high.
- Bus is zero-wait-state (no DTAck stretching), so read data is combinational from current state and all side effects are edge-qualified.

Parameters:
- CLKS_PER_BIT, 434: reset value of the baud divisor (50 MHz / 115200).
- RX_DEPTH, 16: RX FIFO depth in bytes; power of two, range 2..256.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- AS_L  in  1  address strobe, active low
- WE_L  in  1  write enable, active low (1 = read)
- UART_SEL_H  in  1  decoder select for this peripheral
- addr  in  32  word address (byte address >> 2); only addr[1:0] decoded
- wdata  in  32  write data from CPU
- rdata  out  32  read data to bus multiplexer
- tx  out  1  serial transmit, idle high
- rx  in  1  serial receive, asynchronous

Behaviour:
- Bus access: acc = UART_SEL_H & ~AS_L.
  - acc_q is acc registered; acc_start = acc & ~acc_q; acc_end = ~acc & acc_q.
  - addr and WE_L are captured into rd_addr_q/rd_q on acc_start.
- Register map, addr[1:0]:
  - 0 DATA: read = {24'b0, FIFO head}, or 0 if empty. Write [7:0] = TX byte.
  - 1 STATUS, read: bit0 rx_valid (FIFO not empty), bit1 tx_ready, bit2 rx_full, bit3 rx_overrun (sticky), bit4 frame_err (sticky), bits[15:8] rx_count, others 0.
  - 1 STATUS, write: writing 1 to bit3 or bit4 clears that flag.
  - 2 BAUD: [15:0] divisor, read/write. Written values below 4 are stored as 4.
  - 3 CTRL: see Optional Feature.
- rdata is combinational from the current addr and state whenever acc is high; it is 0 when acc is low.
- Writes commit exactly once, on acc_start with WE_L=0, regardless of access length.
- DATA read pop: the FIFO pops once, on the acc_end cycle, when the captured access was a read of DATA and the FIFO was non-empty. Data therefore stays stable throughout the access. Reading DATA when empty has no side effect.
- TX:
  - States IDLE, START, DATA, STOP.
  - A DATA write in IDLE loads the shifter and drops tx_ready the next cycle.
  - START holds tx=0 for BAUD clocks; DATA sends 8 bits LSB first, BAUD clocks each; STOP holds tx=1 for BAUD clocks, then IDLE with tx_ready=1.
  - A DATA write while not IDLE is discarded; the frame in progress is unaffected.
- RX:
  - rx passes through a 2-flop synchroniser (reset value 1).
  - States IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised 0. START samples at BAUD/2 (integer floor): if 1 (glitch), return to IDLE; if 0, go to DATA.
  - DATA samples 8 bits every BAUD clocks, LSB first. STOP samples once after BAUD clocks.
  - Stop sample = 1: push the byte. Stop sample = 0: discard the byte, set frame_err, then wait in IDLE for rx=1 before re-arming.
  - BAUD changes take effect at the next frame start of each engine.
- FIFO:
  - Read/write pointers are one bit wider than the address.
  - Push when full: byte discarded and rx_overrun set. Exception: if a pop occurs in the same cycle, the push is accepted and the count is unchanged.
  - Pop and push in the same cycle when non-full: count unchanged, ordering preserved.
- Reset values (reset mid-frame aborts both engines immediately):
  - tx=1, rdata=0, FIFO empty, all flags 0, BAUD=CLKS_PER_BIT, all state machines IDLE, acc_q=0, CTRL=0.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: CTRL bit0 (loopback) is read/write. When set, the RX engine input is the internal tx signal instead of the synchronised rx pin, and the tx pin is held at 1.
- Undefined: CTRL reads 0, writes are ignored, and RX always uses the rx pin.

Test Plan:
- Reset, then read STATUS → 0x00000002 (tx_ready=1); read BAUD → 434 (0x1B2); tx=1.
- Write BAUD=8, then DATA=0xA5 → tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 8 clocks; tx_ready=0 for 80 clocks. A second DATA write mid-frame is ignored.
- Drive rx frames 0x3C and 0x81 at BAUD=8 → STATUS shows count 2, rx_valid=1. DATA reads return 0x3C then 0x81. The final read leaves STATUS=0x00000002. A 3-cycle read of DATA pops only once.
- Drive 17 frames with RX_DEPTH=16 → rx_full=1, rx_overrun=1, FIFO holds the first 16 bytes. Write STATUS=0x8 → overrun clears and rx_full stays 1.
- Drive a frame with stop bit 0 → frame_err=1, no push. A 2-clock low glitch at BAUD=8 → no frame, no flags.
- With UART_LOOPBACK_EN: set CTRL=1, write DATA=0x5A → tx pin stays 1, FIFO receives 0x5A. Without the macro, CTRL reads 0.
